// File: rtl/spi_memory_burst_pkg.sv
// spi_mem_pkg: shared definitions for the SPI burst memory.
//   - spi_state_e    : FSM state encodings (also driven out on the 4-bit state port)
//   - sample_on_rise : maps CPOL/CPHA to the SCLK edge on which MOSI is sampled
package spi_mem_pkg;

    typedef enum logic [3:0] {
        StIdle        = 4'd0,
        StGetAddr     = 4'd1,
        StReadLoad    = 4'd2,
        StReadXfer    = 4'd3,
        StWriteXfer   = 4'd4,
        StWriteCommit = 4'd5
    } spi_state_e;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_memory_burst_if.sv
// spi_memory_burst_if: the SPI pin bundle between an external master and the memory.
//   sclk_pin, cs_pin (active-low), mosi_pin : master -> slave
//   miso_pin, miso_oe                       : slave -> master (oe high while read data driven)
interface spi_memory_burst_if;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic miso_pin;
    logic miso_oe;

    modport master (
        output sclk_pin,
        output cs_pin,
        output mosi_pin,
        input  miso_pin,
        input  miso_oe
    );

    modport slave (
        input  sclk_pin,
        input  cs_pin,
        input  mosi_pin,
        output miso_pin,
        output miso_oe
    );
endinterface

// File: rtl/spi_memory_burst_pin_sync.sv
// spi_pin_sync: STAGES-flop synchroniser for one asynchronous pin plus a one-flop edge detector.
//   clk, reset : system clock, synchronous active-high reset
//   pin        : asynchronous input
//   level      : synchronised level
//   rise, fall : single-cycle pulses on a synchronised rising / falling edge
// The chain resets to 0 so a pin that is already low at reset release never yields a fall.
module spi_pin_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_memory_burst.sv
// spi_memory_burst: SPI-slave access to a 2**ADDR_W x DATA_W memory with auto-incrementing bursts.
//   clk, reset   : system clock, synchronous active-high reset
//   spi          : SPI pin bundle (slave modport)
//   fault_inject : suppresses commits when built with SPI_MEM_FAULT_EN, otherwise ignored
//   dbg_data     : last word committed to memory
//   state        : current FSM state encoding
// Frame: CS fall, ADDR_W address bits MSB-first, R/W bit (1 = read), then data words until CS rise.
// Optional feature macro: SPI_MEM_FAULT_EN.
module spi_memory_burst
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_memory_burst_if.slave spi,
    input  logic              fault_inject,
    output logic [DATA_W-1:0] dbg_data,
    output logic [3:0]        state
);

    localparam int unsigned DEPTH       = 2 ** ADDR_W;
    localparam int unsigned CNT_W       = $clog2(ADDR_W + DATA_W + 1);
    localparam bit          SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi.sclk_pin),
        .level (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi.cs_pin),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (spi.mosi_pin),
        .level (mosi_lvl),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // SCLK edges only count while CS is (synchronously) low.
    logic samp, shift;
    assign samp  = (SAMPLE_RISE ? sclk_rise : sclk_fall) & ~cs_lvl;
    assign shift = (SAMPLE_RISE ? sclk_fall : sclk_rise) & ~cs_lvl;

    logic commit_en;
`ifdef SPI_MEM_FAULT_EN
    assign commit_en = ~fault_inject;
`else
    logic fault_inject_unused;
    assign fault_inject_unused = fault_inject;
    assign commit_en           = 1'b1;
`endif

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W:0]   hdr_q, hdr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] dbg_q, dbg_d;
    logic              first_q, first_d;
    logic              oe_q, oe_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hdr_q   <= '0;
            addr_q  <= '0;
            shreg_q <= '0;
            dbg_q   <= '0;
            first_q <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            dbg_q   <= dbg_d;
            first_q <= first_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        dbg_d   = dbg_q;
        first_d = first_q;
        oe_d    = oe_q;
        mem_we  = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StGetAddr;
                    cnt_d   = '0;
                end
            end
            StGetAddr: begin
                if (samp) begin
                    hdr_d = {hdr_q[ADDR_W-1:0], mosi_lvl};
                    if (cnt_q == CNT_W'(ADDR_W)) begin
                        cnt_d   = '0;
                        addr_d  = hdr_d[ADDR_W:1];
                        state_d = hdr_d[0] ? StReadLoad : StWriteXfer;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StReadLoad: begin
                shreg_d = mem[addr_q];
                first_d = 1'b1;
                oe_d    = 1'b1;
                cnt_d   = '0;
                state_d = StReadXfer;
            end
            StReadXfer: begin
                // The MSB is already on MISO after the load, so the first shift edge keeps it.
                if (shift) begin
                    if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end
                if (samp) begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        addr_d  = addr_q + 1'b1;
                        state_d = StReadLoad;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWriteXfer: begin
                if (samp) begin
                    shreg_d = {shreg_q[DATA_W-2:0], mosi_lvl};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = StWriteCommit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWriteCommit: begin
                if (commit_en) begin
                    mem_we = 1'b1;
                    dbg_d  = shreg_q;
                end
                addr_d  = addr_q + 1'b1;
                state_d = StWriteXfer;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // CS rise ends the frame from any state; a commit already under way still lands.
        if (cs_rise) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end
    end

    assign spi.miso_pin = oe_q & shreg_q[DATA_W-1];
    assign spi.miso_oe  = oe_q;
    assign dbg_data     = dbg_q;
    assign state        = state_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
module tb_spi_memory_burst;

    localparam int HALF = 8;  // SCLK = clk/16

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, fault_inject, sel, sclk_m, cs_m, mosi_m;
    logic cpol_cur, cpha_cur;

    spi_memory_burst_if if0 ();
    spi_memory_burst_if if3 ();

    // sel = 0 talks to the mode-0 instance, sel = 1 to the mode-3 instance; the idle one sees idle pins.
    assign if0.sclk_pin = sel ? 1'b0 : sclk_m;
    assign if0.cs_pin   = sel ? 1'b1 : cs_m;
    assign if0.mosi_pin = mosi_m;
    assign if3.sclk_pin = sel ? sclk_m : 1'b1;
    assign if3.cs_pin   = sel ? cs_m : 1'b1;
    assign if3.mosi_pin = mosi_m;

    logic [7:0] dbg0, dbg3;
    logic [3:0] st0, st3;

    spi_memory_burst #(
        .ADDR_W(7), .DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)
    ) dut0 (
        .clk(clk), .reset(reset), .spi(if0), .fault_inject(fault_inject),
        .dbg_data(dbg0), .state(st0)
    );

    spi_memory_burst #(
        .ADDR_W(7), .DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)
    ) dut3 (
        .clk(clk), .reset(reset), .spi(if3), .fault_inject(fault_inject),
        .dbg_data(dbg3), .state(st3)
    );

    logic       miso_cur, oe_cur;
    logic [7:0] dbg_cur;
    logic [3:0] st_cur;
    assign miso_cur = sel ? if3.miso_pin : if0.miso_pin;
    assign oe_cur   = sel ? if3.miso_oe : if0.miso_oe;
    assign dbg_cur  = sel ? dbg3 : dbg0;
    assign st_cur   = sel ? st3 : st0;

    typedef struct {
        bit             rd;
        logic [6:0]     addr;
        int             n;
        logic [3:0][7:0] d;       // write words, d[0] sent first
        logic [7:0]     exp_dbg;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model0 [128];
    logic [7:0] model3 [128];
    vec_t       tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic select(input logic m);
        sel      = m;
        cpol_cur = m;
        cpha_cur = m;
        sclk_m   = m;
    endtask

    // One SPI bit; master reads MISO just before its sample edge.
    task automatic xfer_bit(input logic bo, output logic bi);
        if (!cpha_cur) begin
            mosi_m = bo;
            clks(HALF);
            bi     = miso_cur;
            sclk_m = ~cpol_cur;
            clks(HALF);
            sclk_m = cpol_cur;
        end else begin
            sclk_m = ~cpol_cur;
            mosi_m = bo;
            clks(HALF);
            bi     = miso_cur;
            sclk_m = cpol_cur;
            clks(HALF);
        end
    endtask

    task automatic frame_start();
        cs_m = 1'b0;
        clks(HALF);
    endtask

    task automatic frame_stop();
        clks(HALF);
        cs_m = 1'b1;
        clks(2 * HALF);
    endtask

    task automatic send_header(input logic [6:0] a, input logic rw);
        logic b;
        for (int i = 6; i >= 0; i--) xfer_bit(a[i], b);
        check("oe_in_addr_phase", 32'(oe_cur), 32'd0);
        xfer_bit(rw, b);
    endtask

    task automatic write_word(input logic [7:0] w);
        logic b;
        for (int i = 7; i >= 0; i--) xfer_bit(w[i], b);
    endtask

    task automatic read_word(input string name);
        logic       b;
        logic [7:0] w;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b0, b);
            if (i == 7) check({name, "_oe"}, 32'(oe_cur), 32'd1);
            w[i] = b;
        end
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'(w), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(w), 32'(e));
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [6:0] a;
        frame_start();
        send_header(v.addr, v.rd);
        for (int k = 0; k < v.n; k++) begin
            a = v.addr + 7'(k);
            if (v.rd) begin
                exp_q.push_back(sel ? model3[a] : model0[a]);
                read_word($sformatf("%s_rd%0d", name, k));
            end else begin
                write_word(v.d[k]);
                if (sel) model3[a] = v.d[k];
                else     model0[a] = v.d[k];
            end
        end
        frame_stop();
        check({name, "_dbg"}, 32'(dbg_cur), 32'(v.exp_dbg));
        check({name, "_state_idle"}, 32'(st_cur), 32'd0);
        check({name, "_oe_after"}, 32'(oe_cur), 32'd0);
        check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic b;
        vec_t v;

        tbl[0] = '{rd:1'b0, addr:7'h12, n:1, d:32'h0000_00A5, exp_dbg:8'hA5};
        tbl[1] = '{rd:1'b1, addr:7'h12, n:1, d:32'h0,         exp_dbg:8'hA5};
        tbl[2] = '{rd:1'b0, addr:7'h7E, n:3, d:32'h0033_2211, exp_dbg:8'h33};
        tbl[3] = '{rd:1'b1, addr:7'h7E, n:3, d:32'h0,         exp_dbg:8'h33};
        tbl[4] = '{rd:1'b1, addr:7'h00, n:1, d:32'h0,         exp_dbg:8'h33};
        tbl[5] = '{rd:1'b0, addr:7'h05, n:1, d:32'h0000_005A, exp_dbg:8'h5A};
        tbl[6] = '{rd:1'b0, addr:7'h30, n:4, d:32'hFE01_96C3, exp_dbg:8'hFE};
        tbl[7] = '{rd:1'b1, addr:7'h7F, n:2, d:32'h0,         exp_dbg:8'hFE};
        tbl[8] = '{rd:1'b1, addr:7'h30, n:4, d:32'h0,         exp_dbg:8'hFE};
        tbl[9] = '{rd:1'b1, addr:7'h05, n:1, d:32'h0,         exp_dbg:8'hFE};

        // Reset with pins idle.
        reset        = 1'b1;
        fault_inject = 1'b0;
        cs_m         = 1'b1;
        mosi_m       = 1'b0;
        select(1'b0);
        clks(3);
        check("rst_miso0", 32'(if0.miso_pin), 32'd0);
        check("rst_oe0", 32'(if0.miso_oe), 32'd0);
        check("rst_state0", 32'(st0), 32'd0);
        check("rst_dbg0", 32'(dbg0), 32'd0);
        check("rst_state3", 32'(st3), 32'd0);
        check("rst_dbg3", 32'(dbg3), 32'd0);
        reset = 1'b0;
        clks(4);

        // Mode 0: single, burst, wrap.
        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // CS raised after 4 data bits: no commit.
        frame_start();
        send_header(7'h05, 1'b0);
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, b);
        check("partial_state_wxfer", 32'(st0), 32'd4);
        frame_stop();
        check("partial_state_idle", 32'(st0), 32'd0);
        check("partial_dbg", 32'(dbg0), 32'hFE);
        v = '{rd:1'b1, addr:7'h05, n:1, d:32'h0, exp_dbg:8'hFE};
        run_vec("partial_rd", v);

        // Reset mid-frame; CS stays low across release so the frame is abandoned.
        frame_start();
        for (int i = 0; i < 3; i++) xfer_bit(1'b0, b);
        check("midrst_getaddr", 32'(st0), 32'd1);
        reset = 1'b1;
        clks(1);
        check("midrst_idle", 32'(st0), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) xfer_bit(1'b1, b);
        check("midrst_stays_idle", 32'(st0), 32'd0);
        check("midrst_dbg", 32'(dbg0), 32'd0);
        cs_m = 1'b1;
        clks(2 * HALF);

        // Mode 3 instance.
        select(1'b1);
        clks(4);
        v = '{rd:1'b0, addr:7'h40, n:1, d:32'h0000_003C, exp_dbg:8'h3C};
        run_vec("m3_wr", v);
        v = '{rd:1'b1, addr:7'h40, n:1, d:32'h0, exp_dbg:8'h3C};
        run_vec("m3_rd", v);
        select(1'b0);
        clks(4);

        // Fault injection on a write to 0x05 (holds 0x5A).
        v = '{rd:1'b0, addr:7'h06, n:1, d:32'h0000_0081, exp_dbg:8'h81};
        run_vec("pre_fault_wr", v);
        fault_inject = 1'b1;
`ifdef SPI_MEM_FAULT_EN
        v = '{rd:1'b0, addr:7'h05, n:2, d:32'h0000_FFFF, exp_dbg:8'h81};
        run_vec("fault_wr", v);
        model0[7'h05] = 8'h5A;
        model0[7'h06] = 8'h81;
`else
        v = '{rd:1'b0, addr:7'h05, n:2, d:32'h0000_77FF, exp_dbg:8'h77};
        run_vec("fault_wr", v);
`endif
        fault_inject = 1'b0;
        v = '{rd:1'b1, addr:7'h05, n:2, d:32'h0, exp_dbg:dbg0};
`ifdef SPI_MEM_FAULT_EN
        v.exp_dbg = 8'h81;
`else
        v.exp_dbg = 8'h77;
`endif
        run_vec("fault_rd", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
